// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_pkg
// Brief    : Shared stall-vector constants and divide FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    // Stall vector bit order: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_hazard_detect
// Brief    : Combinational load-use comparator for the two ID read ports.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       i_id_re1,
    input  logic [4:0] i_id_raddr1,
    input  logic       i_id_re2,
    input  logic [4:0] i_id_raddr2,
    input  logic       i_ex_wreg,
    input  logic [4:0] i_ex_waddr,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic w_port1_hit;
    logic w_port2_hit;
    logic w_load_dest;

    // r0 is hardwired to zero, so a load targeting it never produces a hazard
    assign w_load_dest = i_ex_is_load & i_ex_wreg & (i_ex_waddr != 5'd0);
    assign w_port1_hit = i_id_re1 & (i_id_raddr1 == i_ex_waddr);
    assign w_port2_hit = i_id_re2 & (i_id_raddr2 == i_ex_waddr);
    assign o_load_use  = w_load_dest & (w_port1_hit | w_port2_hit);

endmodule : pipe_stall_ctrl_hazard_detect
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline stall/flush controller with divide sequencing and a
//            stall-cycle performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_re1,
    input  logic [4:0]         id_raddr1,
    input  logic               id_re2,
    input  logic [4:0]         id_raddr2,
    input  logic               ex_wreg,
    input  logic [4:0]         ex_waddr,
    input  logic               ex_is_load,
    input  logic               ex_div_op,
    input  logic               div_ready,
    input  logic               excp_flag,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               div_start,
    output logic               div_cancel,
    output logic               div_busy,
    output logic [CNT_W-1:0]   stall_cnt
);

    div_state_e         r_state_q;
    div_state_e         w_state_d;
    logic [CNT_W-1:0]   r_stall_cnt_q;
    logic [CNT_W-1:0]   w_stall_cnt_d;

    logic               w_load_use;
    logic               w_ex_stall;
    logic               w_div_start;
    logic               w_div_cancel;
    logic               w_flush;
    logic [STALL_W-1:0] w_stall;

    pipe_stall_ctrl_hazard_detect u_hazard_detect (
        .i_id_re1     (id_re1),
        .i_id_raddr1  (id_raddr1),
        .i_id_re2     (id_re2),
        .i_id_raddr2  (id_raddr2),
        .i_ex_wreg    (ex_wreg),
        .i_ex_waddr   (ex_waddr),
        .i_ex_is_load (ex_is_load),
        .o_load_use   (w_load_use)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_ex_stall   = 1'b0;
        w_div_start  = 1'b0;
        w_div_cancel = 1'b0;
        case (r_state_q)
            DIV_IDLE: begin
                if (ex_div_op) begin
                    w_ex_stall = 1'b1;
                    if (!excp_flag) begin
                        w_div_start = 1'b1;
                        w_state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                w_ex_stall = 1'b1;
                if (div_ready) begin
                    w_state_d = DIV_DONE;
                end
            end
            // One-cycle window where EX/MEM captures the result; never relaunches
            DIV_DONE: begin
                w_state_d = DIV_IDLE;
            end
            default: begin
                w_state_d = DIV_IDLE;
            end
        endcase
        // Exception overrides everything, including a coincident div_ready
        if (excp_flag) begin
            w_state_d    = DIV_IDLE;
            w_div_cancel = (r_state_q == DIV_BUSY);
        end
    end

    always_comb begin
        w_flush = 1'b0;
        w_stall = STALL_W'(STALL_NONE);
        if (excp_flag) begin
            w_flush = 1'b1;
        end else if (w_ex_stall) begin
            w_stall = STALL_W'(STALL_EX);
        end else if (w_load_use) begin
            w_stall = STALL_W'(STALL_ID);
        end
    end

    // Outputs are forced quiet during reset so a reset mid-divide sends no cancel
    assign stall      = rst ? STALL_W'(STALL_NONE) : w_stall;
    assign flush      = w_flush      & ~rst;
    assign div_start  = w_div_start  & ~rst;
    assign div_cancel = w_div_cancel & ~rst;
    assign div_busy   = (r_state_q == DIV_BUSY) & ~rst;
    assign stall_cnt  = r_stall_cnt_q;

    assign w_stall_cnt_d = r_stall_cnt_q + {{(CNT_W-1){1'b0}}, (|w_stall)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= DIV_IDLE;
            r_stall_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Scoreboard bench for pipe_stall_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int STALL_W = 6;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_re1, id_re2, ex_wreg, ex_is_load, ex_div_op, div_ready, excp_flag;
    logic [4:0]         id_raddr1, id_raddr2, ex_waddr;
    logic [STALL_W-1:0] stall;
    logic               flush, div_start, div_cancel, div_busy;
    logic [CNT_W-1:0]   stall_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_re1(id_re1), .id_raddr1(id_raddr1), .id_re2(id_re2), .id_raddr2(id_raddr2),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
        .ex_div_op(ex_div_op), .div_ready(div_ready), .excp_flag(excp_flag),
        .stall(stall), .flush(flush), .div_start(div_start), .div_cancel(div_cancel),
        .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [STALL_W-1:0] stall;
        logic               flush;
        logic               start;
        logic               cancel;
        logic               busy;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: a divide is either in flight, just finished, or absent
    bit               m_in_flight;
    bit               m_result_cycle;
    int unsigned      m_stall_cycles;

    task automatic step(input bit r, input bit re1, input bit [4:0] a1,
                        input bit re2, input bit [4:0] a2, input bit wreg,
                        input bit [4:0] wa, input bit ld, input bit dv,
                        input bit rdy, input bit ex);
        exp_t e;
        bit   hazard, launching, holding_ex;
        @(posedge clk);
        #1;
        rst = r; id_re1 = re1; id_raddr1 = a1; id_re2 = re2; id_raddr2 = a2;
        ex_wreg = wreg; ex_waddr = wa; ex_is_load = ld; ex_div_op = dv;
        div_ready = rdy; excp_flag = ex;
        e = '0;
        e.cnt = CNT_W'(m_stall_cycles);
        if (r) begin
            q.push_back(e);
            m_in_flight = 0; m_result_cycle = 0; m_stall_cycles = 0;
            return;
        end
        hazard = ld && wreg && wa != 0 && ((re1 && a1 == wa) || (re2 && a2 == wa));
        launching  = dv && !m_in_flight && !m_result_cycle;
        holding_ex = launching || m_in_flight;
        e.busy = m_in_flight;
        if (ex) begin
            e.flush  = 1;
            e.cancel = m_in_flight;
            m_in_flight = 0; m_result_cycle = 0;
        end else begin
            if (holding_ex)  e.stall = 6'b001111;
            else if (hazard) e.stall = 6'b000111;
            e.start = launching;
            if (m_result_cycle)            m_result_cycle = 0;
            else if (launching)            m_in_flight = 1;
            else if (m_in_flight && rdy) begin m_in_flight = 0; m_result_cycle = 1; end
        end
        if (e.stall != 0) m_stall_cycles = m_stall_cycles + 1;
        q.push_back(e);
    endtask

    task automatic idle_cycle(input bit dv, input bit rdy, input bit ex);
        step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, dv, rdy, ex);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("stall",      32'(stall),      32'(e.stall));
            cmp("flush",      32'(flush),      32'(e.flush));
            cmp("div_start",  32'(div_start),  32'(e.start));
            cmp("div_cancel", 32'(div_cancel), 32'(e.cancel));
            cmp("div_busy",   32'(div_busy),   32'(e.busy));
            cmp("stall_cnt",  32'(stall_cnt),  32'(e.cnt));
        end
    end

    initial begin
        m_in_flight = 0; m_result_cycle = 0; m_stall_cycles = 0;
        rst = 1; id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
        ex_wreg = 0; ex_waddr = 0; ex_is_load = 0; ex_div_op = 0;
        div_ready = 0; excp_flag = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cycle(0, 0, 0);

        // Load-use on r5, then the same shape on r0
        step(0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 1, 0, 0, 0);
        idle_cycle(0, 0, 0);
        step(0, 1, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
        step(0, 0, 5'd0, 1, 5'd9, 1, 5'd9, 1, 0, 0, 0);
        idle_cycle(0, 0, 0);

        // Divide with ready four cycles after launch, op held through DONE
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(1, 1, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(0, 1, 0);

        // Exception two cycles into BUSY with a coincident div_ready
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        idle_cycle(1, 1, 1);
        idle_cycle(0, 1, 0);

        // Priority: divide decode beats load-use, exception beats both
        step(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 1, 1, 0, 0);
        step(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 1, 1, 0, 1);
        idle_cycle(0, 0, 1);
        step(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 1, 1, 0, 1);
        idle_cycle(0, 0, 0);

        // Reset in the middle of BUSY
        idle_cycle(1, 0, 0);
        idle_cycle(1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycle(0, 0, 0);

        // Drive the counter past its top to observe the wrap
        for (int i = 0; i < (1 << CNT_W) + 4; i++)
            step(0, 1, 5'd7, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0);
        idle_cycle(0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            bit dv, ld;
            dv = ($urandom_range(0, 99) < 30);
            ld = !dv && ($urandom_range(0, 99) < 50);
            step(($urandom_range(0, 99) < 2),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 ld, dv,
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 5));
        end
        idle_cycle(0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
